// File: rtl/multi_channel_clock_divider.sv
// Programmable multi-channel integer clock divider.
// Each channel produces a registered divided clock and a period-start tick; divisor changes land only on period boundaries.
module multi_channel_clock_divider #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      EN,
    input  logic [CHANNELS-1:0]       LOAD,
    input  logic [CHANNELS*WIDTH-1:0] DIV_IN,
    output logic [CHANNELS-1:0]       CLK_OUT,
    output logic [CHANNELS-1:0]       TICK,
    output logic                      BUSY
);

    localparam int unsigned HW = WIDTH + 1;

    logic [CHANNELS-1:0] w_pend_v_nxt;
    logic                r_busy;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_active;
        logic [WIDTH-1:0] r_pending;
        logic             r_pend_v;
        logic             r_clk_out;
        logic             r_tick;

        logic [WIDTH-1:0] w_div;
        logic [WIDTH-1:0] w_nxt_div;
        logic [WIDTH-1:0] w_cnt_nxt;
        logic [WIDTH-1:0] w_active_nxt;
        logic [WIDTH-1:0] w_pending_nxt;
        logic [HW-1:0]    w_half;
        logic             w_boundary;
        logic             w_pend_v;
        logic             w_clk_nxt;
        logic             w_tick_nxt;

        // Next-state for one channel; the half-period is computed one bit wider so D=2^WIDTH-1 cannot overflow.
        always_comb begin
            w_div         = DIV_IN[k*WIDTH +: WIDTH];
            w_half        = HW'((HW'(r_active) + HW'(1)) >> 1);
            w_boundary    = (r_active <= WIDTH'(1)) || (r_cnt == r_active - WIDTH'(1));
            w_nxt_div     = LOAD[k] ? w_div : r_pending;
            w_cnt_nxt     = r_cnt;
            w_active_nxt  = r_active;
            w_pending_nxt = r_pending;
            w_pend_v      = r_pend_v;
            w_clk_nxt     = r_clk_out;
            w_tick_nxt    = r_tick;
            if (EN) begin
                w_clk_nxt  = (r_active != '0) && (HW'(r_cnt) < w_half);
                w_tick_nxt = (r_active != '0) && (r_cnt == '0);
                w_cnt_nxt  = w_boundary ? '0 : r_cnt + WIDTH'(1);
                if (w_boundary && (LOAD[k] || r_pend_v)) begin
                    w_active_nxt = w_nxt_div;
                    w_pend_v     = 1'b0;
                end else if (LOAD[k]) begin
                    w_pending_nxt = w_div;
                    w_pend_v      = 1'b1;
                end
            end else if (LOAD[k]) begin
                w_pending_nxt = w_div;
                w_pend_v      = 1'b1;
            end
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                r_cnt     <= '0;
                r_active  <= WIDTH'(DEFAULT_DIV);
                r_pending <= '0;
                r_pend_v  <= 1'b0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                r_cnt     <= w_cnt_nxt;
                r_active  <= w_active_nxt;
                r_pending <= w_pending_nxt;
                r_pend_v  <= w_pend_v;
                r_clk_out <= w_clk_nxt;
                r_tick    <= w_tick_nxt;
            end
        end

        assign w_pend_v_nxt[k] = w_pend_v;
        assign CLK_OUT[k]      = r_clk_out;
        assign TICK[k]         = r_tick;
    end

    // BUSY tracks the post-edge pending state of all channels.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_pend_v_nxt;
        end
    end

    assign BUSY = r_busy;

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Bench for multi_channel_clock_divider: directed scenarios plus random traffic,
// checked every cycle against a period/position reference model.
module tb_multi_channel_clock_divider;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           EN;
    logic [N-1:0]   LOAD;
    logic [N*W-1:0] DIV_IN;
    logic [N-1:0]   CLK_OUT;
    logic [N-1:0]   TICK;
    logic           BUSY;

    multi_channel_clock_divider #(.WIDTH(W), .CHANNELS(N), .DEFAULT_DIV(2)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .DIV_IN(DIV_IN),
        .CLK_OUT(CLK_OUT), .TICK(TICK), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference: position within the current period, period length, latest requested divisor.
    int       pos  [N];
    int       per  [N];
    int       pend [N];
    bit       pv   [N];
    logic [N-1:0] exp_clk;
    logic [N-1:0] exp_tick;
    logic         exp_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            pos[k] = 0; per[k] = 2; pend[k] = 0; pv[k] = 1'b0;
        end
        exp_clk = '0; exp_tick = '0; exp_busy = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic [N-1:0] ld, input logic [N*W-1:0] dv);
        int  d;
        bit  last;
        for (int k = 0; k < N; k++) begin
            d = int'(dv[k*W +: W]);
            if (en) begin
                exp_clk[k]  = (per[k] != 0) && (pos[k] < (per[k] + 1) / 2);
                exp_tick[k] = (per[k] != 0) && (pos[k] == 0);
                last        = (per[k] <= 1) || (pos[k] == per[k] - 1);
                pos[k]      = last ? 0 : pos[k] + 1;
                if (last && (ld[k] || pv[k])) begin
                    per[k] = ld[k] ? d : pend[k];
                    pv[k]  = 1'b0;
                end else if (ld[k]) begin
                    pend[k] = d; pv[k] = 1'b1;
                end
            end else if (ld[k]) begin
                pend[k] = d; pv[k] = 1'b1;
            end
        end
        exp_busy = 1'b0;
        for (int k = 0; k < N; k++) exp_busy |= pv[k];
    endtask

    task automatic step(input logic en, input logic [N-1:0] ld, input logic [N*W-1:0] dv);
        EN = en; LOAD = ld; DIV_IN = dv;
        @(posedge CLK); #1;
        model_edge(en, ld, dv);
        LOAD = '0;
        check("clk_out", 32'(CLK_OUT), 32'(exp_clk));
        check("tick",    32'(TICK),    32'(exp_tick));
        check("busy",    32'(BUSY),    32'(exp_busy));
    endtask

    function automatic logic [N*W-1:0] dv1(input int ch, input int val);
        logic [N*W-1:0] v;
        v = '0;
        v[ch*W +: W] = W'(val);
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, '0);
    endtask

    // Advance until the next edge sees position p on channel ch.
    task automatic wait_pos(input int ch, input int p);
        int n;
        n = 0;
        while (pos[ch] != p && n < 600) begin
            step(1'b1, '0, '0);
            n++;
        end
        if (n >= 600) begin
            checks++; errors++;
            $error("FAIL wait_pos: observed timeout expected position %0d", p);
        end
    endtask

    task automatic wait_applied(input int ch, input int d);
        int n;
        n = 0;
        while (!(per[ch] == d && !pv[ch]) && n < 600) begin
            step(1'b1, '0, '0);
            n++;
        end
        if (n >= 600) begin
            checks++; errors++;
            $error("FAIL wait_applied: observed timeout expected divisor %0d", d);
        end
    endtask

    initial begin
        int highs;
        int ticks;
        logic [N-1:0]   rl;
        logic [N*W-1:0] rd;

        RESET = 1'b1; EN = 1'b0; LOAD = '0; DIV_IN = '0;
        model_reset();
        #12;
        check("rst_clk_out", 32'(CLK_OUT), 32'h0);
        check("rst_tick",    32'(TICK),    32'h0);
        check("rst_busy",    32'(BUSY),    32'h0);
        RESET = 1'b0;

        // Default divide-by-2 on every channel.
        idle(8);

        // Mixed divisors loaded while all channels are at position 0.
        step(1'b1, 4'b1111, {8'd0, 8'd1, 8'd5, 8'd3});
        idle(30);

        // Mid-period reload completes the old 8-cycle period.
        step(1'b1, 4'b0001, dv1(0, 8));
        wait_applied(0, 8);
        wait_pos(0, 2);
        step(1'b1, 4'b0001, dv1(0, 4));
        check("busy_after_midload", 32'(BUSY), 32'h1);
        wait_applied(0, 4);
        idle(12);

        // Newest LOAD wins; boundary-edge LOAD bypasses pending.
        step(1'b1, 4'b0001, dv1(0, 8));
        wait_applied(0, 8);
        wait_pos(0, 1);
        step(1'b1, 4'b0001, dv1(0, 6));
        wait_pos(0, 5);
        step(1'b1, 4'b0001, dv1(0, 3));
        wait_applied(0, 3);
        idle(6);
        wait_pos(0, 2);
        step(1'b1, 4'b0001, dv1(0, 5));
        check("busy_boundary_load", 32'(BUSY), 32'h0);
        idle(12);

        // Full-range divisor on channel 1.
        step(1'b1, 4'b0010, dv1(1, 255));
        wait_applied(1, 255);
        highs = 0; ticks = 0;
        for (int i = 0; i < 255; i++) begin
            step(1'b1, '0, '0);
            highs += int'(CLK_OUT[1]);
            ticks += int'(TICK[1]);
        end
        check("d255_high_cycles", 32'(highs), 32'd128);
        check("d255_ticks",       32'(ticks), 32'd1);

        // Freeze with EN low while a new divisor is captured.
        step(1'b1, 4'b0001, dv1(0, 8));
        wait_applied(0, 8);
        wait_pos(0, 3);
        for (int i = 0; i < 10; i++) step(1'b0, (i == 2) ? 4'b0001 : 4'b0000, dv1(0, 4));
        check("busy_frozen", 32'(BUSY), 32'h1);
        idle(20);

        // Asynchronous reset mid-period with a divisor pending.
        step(1'b1, 4'b0001, dv1(0, 7));
        wait_applied(0, 7);
        wait_pos(0, 2);
        step(1'b1, 4'b0001, dv1(0, 9));
        check("busy_before_reset", 32'(BUSY), 32'h1);
        RESET = 1'b1;
        #1;
        model_reset();
        check("async_rst_clk_out", 32'(CLK_OUT), 32'h0);
        check("async_rst_tick",    32'(TICK),    32'h0);
        check("async_rst_busy",    32'(BUSY),    32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        idle(8);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < N; k++) begin
                rl[k] = ($urandom_range(0, 11) == 0);
                rd[k*W +: W] = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 255))
                                                            : W'($urandom_range(0, 9));
            end
            step($urandom_range(0, 7) != 0, rl, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
